// File: rtl/od_line_if.sv
// Open-drain line driver signal bundle: bit request handshake, filtered bus levels, pad enable and status.
interface od_line_if;
  logic req_valid;
  logic req_bit;
  logic req_ready;
  logic scl_f;
  logic sda_f;
  logic abort;
  logic oe;
  logic done;
  logic conflict;

  modport slave (
    input  req_valid,
    input  req_bit,
    input  scl_f,
    input  sda_f,
    input  abort,
    output req_ready,
    output oe,
    output done,
    output conflict
  );

  modport master (
    output req_valid,
    output req_bit,
    output scl_f,
    output sda_f,
    output abort,
    input  req_ready,
    input  oe,
    input  done,
    input  conflict
  );
endinterface

// File: rtl/od_line_driver.sv
// Drives one SDA bit per request after SCL has been low HOLD_CYCLES, then checks the readback at SCL high.
// oe moves HOLD_CYCLES edges after accept (SCL low); req_ready is high only while idle.
module od_line_driver #(
  parameter int HOLD_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic      clk,
  input  logic      rstn,
  od_line_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOW  = 3'd1,
    HOLD      = 3'd2,
    SETTLE    = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             oe_q, oe_d;
  logic             done_q, done_d;
  logic             conflict_q, conflict_d;
  logic             up_q, up_d;

  logic req_ready;
  logic accept;

  // up_q keeps req_ready low until the first edge after reset release.
  assign req_ready = (state_q == IDLE) && up_q;
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lvl_d      = lvl_q;
    oe_d       = oe_q;
    done_d     = 1'b0;
    conflict_d = 1'b0;
    up_d       = 1'b1;

    if (bus.abort) begin
      state_d = IDLE;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            lvl_d   = bus.req_bit;
            cnt_d   = HOLD_LD;
            state_d = bus.scl_f ? WAIT_LOW : HOLD;
          end
        end
        WAIT_LOW: begin
          if (!bus.scl_f) begin
            cnt_d   = HOLD_LD;
            state_d = HOLD;
          end
        end
        HOLD: begin
          // Any SCL high glitch restarts the full hold window.
          if (bus.scl_f) begin
            cnt_d   = HOLD_LD;
            state_d = WAIT_LOW;
          end else if (cnt_q <= CNT_ONE) begin
            oe_d    = ~lvl_q;
            cnt_d   = SETTLE_LD;
            state_d = SETTLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        SETTLE: begin
          if (cnt_q <= CNT_ONE) begin
            state_d = WAIT_HIGH;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          if (bus.scl_f) begin
            done_d     = 1'b1;
            conflict_d = (bus.sda_f != lvl_q);
            state_d    = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lvl_q      <= 1'b1;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
      up_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
      conflict_q <= conflict_d;
      up_q       <= up_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.oe        = oe_q;
  assign bus.done      = done_q;
  assign bus.conflict  = conflict_q;

endmodule

// File: tb/tb_od_line_driver.sv
// Directed scenarios plus randomized traffic, every cycle compared against a bit-level behavioural model.
module tb_od_line_driver;
  localparam int HOLD   = 8;
  localparam int SETTLE = 4;

  logic clk;
  logic rstn;
  od_line_if bus ();

  od_line_driver #(.HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a bit in flight needs HOLD consecutive low samples plus one more low edge,
  // then SETTLE ignored edges, then completes on the first high SCL sample.
  bit m_busy, m_bit, m_oe, m_done, m_conf, m_up, m_applied;
  int m_lows, m_after;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_bit = 1; m_oe = 0; m_done = 0; m_conf = 0; m_up = 0;
    m_applied = 0; m_lows = 0; m_after = 0;
  endtask

  task automatic model_edge();
    bit ready;
    if (rstn) begin
      model_reset();
      return;
    end
    ready  = m_up && !m_busy;
    m_done = 0;
    m_conf = 0;
    if (bus.abort) begin
      m_busy = 0;
      m_oe   = 0;
    end else if (!m_busy) begin
      if (bus.req_valid && ready) begin
        m_busy    = 1;
        m_bit     = bus.req_bit;
        m_applied = 0;
        m_lows    = bus.scl_f ? 0 : 1;
      end
    end else if (!m_applied) begin
      if (bus.scl_f) m_lows = 0;
      else if (m_lows == HOLD) begin
        m_oe      = !m_bit;
        m_applied = 1;
        m_after   = 0;
      end else m_lows++;
    end else if (m_after < SETTLE) begin
      m_after++;
    end else if (bus.scl_f) begin
      m_done = 1;
      m_conf = (bus.sda_f != m_bit);
      m_busy = 0;
    end
    m_up = 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("oe", bus.oe, m_oe);
    check("done", bus.done, m_done);
    check("conflict", bus.conflict, m_conf);
    check("req_ready", bus.req_ready, m_up && !m_busy);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input bit b);
    bus.req_valid = 1; bus.req_bit = b;
    step();
    bus.req_valid = 0;
  endtask

  initial begin
    rstn = 1;
    bus.req_valid = 1; bus.req_bit = 0; bus.scl_f = 1; bus.sda_f = 1; bus.abort = 0;
    model_reset();

    // Reset with request pending
    steps(2);
    check("rst_oe", bus.oe, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_done", bus.done, 0);
    rstn = 0;
    step();
    check("rel_ready", bus.req_ready, 1);
    check("rel_oe", bus.oe, 0);
    bus.req_valid = 0;

    // Drive low with SCL low and steady
    bus.scl_f = 0;
    send(0);
    for (int i = 1; i < HOLD; i++) begin step(); check("low_oe_early", bus.oe, 0); end
    step(); check("low_oe_at8", bus.oe, 1);
    bus.sda_f = 0;
    steps(SETTLE);
    bus.scl_f = 1;
    step(); check("low_done", bus.done, 1); check("low_conf", bus.conflict, 0);
    step(); check("low_done_once", bus.done, 0); check("low_ready", bus.req_ready, 1);

    // SCL high at accept
    bus.abort = 1; step(); bus.abort = 0; bus.sda_f = 1;
    send(0);
    for (int i = 0; i < 3; i++) begin step(); check("hi_oe_wait", bus.oe, 0); end
    bus.scl_f = 0;
    step();
    for (int i = 1; i < HOLD; i++) begin step(); check("hi_oe_early", bus.oe, 0); end
    step(); check("hi_oe_f8", bus.oe, 1);
    bus.sda_f = 0;
    steps(SETTLE);
    bus.scl_f = 1;
    step(); check("hi_done", bus.done, 1);
    step();

    // Hold restart, then conflict on a release bit
    bus.scl_f = 0; step();
    send(1);
    steps(5);
    bus.scl_f = 1; step();
    bus.scl_f = 0; step();
    for (int i = 1; i < HOLD; i++) begin step(); check("rs_oe_early", bus.oe, 1); end
    step(); check("rs_oe_g8", bus.oe, 0);
    bus.sda_f = 0;
    steps(SETTLE);
    bus.scl_f = 1;
    step(); check("cf_done", bus.done, 1); check("cf_conf", bus.conflict, 1);
    step(); check("cf_done_once", bus.done, 0); check("cf_conf_once", bus.conflict, 0);

    // Abort in HOLD and in SETTLE; abort beats a request in IDLE
    bus.sda_f = 1; bus.scl_f = 0; step();
    send(0); steps(3);
    bus.abort = 1; step(); bus.abort = 0;
    check("ab_hold_ready", bus.req_ready, 1);
    check("ab_hold_done", bus.done, 0);
    send(0); steps(HOLD);
    check("ab_set_oe_pre", bus.oe, 1);
    bus.abort = 1; step(); bus.abort = 0;
    check("ab_set_oe", bus.oe, 0);
    bus.scl_f = 1; steps(3); bus.scl_f = 0; steps(2);
    bus.abort = 1; bus.req_valid = 1; step();
    bus.abort = 0; bus.req_valid = 0; step();
    check("ab_idle_ready", bus.req_ready, 1);

    // Reset during SETTLE
    send(0); steps(HOLD);
    step();
    check("rs_set_oe_pre", bus.oe, 1);
    rstn = 1; #1;
    model_reset();
    check("rs_async_oe", bus.oe, 0);
    steps(2);
    rstn = 0; bus.scl_f = 1;
    steps(10);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 14) == 0) bus.scl_f = ~bus.scl_f;
      bus.sda_f     = bus.oe ? 1'b0 : ($urandom_range(0, 5) != 0);
      bus.abort     = ($urandom_range(0, 149) == 0);
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_bit   = $urandom_range(0, 1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
